// File: rtl/led_trail_pkg.sv
// ============================================================================
// Module      : led_trail_pkg
// Description : Shared helpers for the LED afterglow dimmer: full-scale
//               derivation, saturating decay and the optional gamma map used
//               when LED_TRAIL_GAMMA_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_trail_pkg;

    function automatic int max_level(input int bw);
        return (1 << bw) - 1;
    endfunction

    // Decay never wraps: anything at or below the step lands on zero.
    function automatic int sat_dec(input int lvl, input int dec);
        return (lvl > dec) ? (lvl - dec) : 0;
    endfunction

    function automatic int gamma_map(input int lvl, input int bw);
        return ((lvl * lvl) >> bw) & max_level(bw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_trail_chan.sv
// ============================================================================
// Module      : led_trail_chan
// Description : One LED channel: level register with refill/decay, effective
//               level mapping (quadratic when LED_TRAIL_GAMMA_EN is defined)
//               and the registered PWM compare output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_trail_chan
    import led_trail_pkg::*;
#(
    parameter int BW    = 4,
    parameter int DECAY = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          I,
    input  logic          CE,
    input  logic [BW-1:0] pwm_cnt,
    output logic          O
);

    localparam logic [BW-1:0] c_max = BW'(max_level(BW));

    logic [BW-1:0] r_lvl;
    logic [BW-1:0] w_eff;
    logic          r_o;

`ifdef LED_TRAIL_GAMMA_EN
    assign w_eff = BW'(gamma_map(int'(r_lvl), BW));
`else
    assign w_eff = r_lvl;
`endif

    // Refill beats a coincident decay tick, so a lit LED never dims.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_lvl <= '0;
            r_o   <= 1'b0;
        end else begin
            if (I) begin
                r_lvl <= c_max;
            end else if (CE) begin
                r_lvl <= BW'(sat_dec(int'(r_lvl), DECAY));
            end
            r_o <= (w_eff > pwm_cnt);
        end
    end

    assign O = r_o;

endmodule

`default_nettype wire

// File: rtl/led_trail_pwm.sv
// ============================================================================
// Module      : led_trail_pwm
// Description : Per-LED afterglow dimmer behind the ring pattern generator.
//               Shared free-running PWM counter plus N independent channels.
//               Define LED_TRAIL_GAMMA_EN for a quadratic brightness map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int N     = 8,
    parameter int BW    = 4,
    parameter int DECAY = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] I,
    input  logic         CE,
    output logic [N-1:0] O
);

    logic [BW-1:0] r_pwm_cnt;
    logic [N-1:0]  w_o;

    // Natural overflow gives the MAX -> 0 wrap and a 2**BW cycle period.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + BW'(1);
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_chan
            led_trail_chan #(
                .BW    (BW),
                .DECAY (DECAY)
            ) u_chan (
                .CLK     (CLK),
                .RESET   (RESET),
                .I       (I[k]),
                .CE      (CE),
                .pwm_cnt (r_pwm_cnt),
                .O       (w_o[k])
            );
        end
    endgenerate

    assign O = w_o;

endmodule

`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
// ============================================================================
// Module      : tb_led_trail_pwm
// Description : Directed bench for led_trail_pwm (DECAY=1 and DECAY=3 builds),
//               duty measured over 16-cycle windows at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_trail_pwm;

    logic       clk;
    logic       rst;
    logic [7:0] i_ring;
    logic       ce;
    logic [7:0] o_led;
    logic [7:0] i_ring3;
    logic       ce3;
    logic [7:0] o_led3;

    int errors = 0;
    int checks = 0;

    led_trail_pwm #(.N(8), .BW(4), .DECAY(1)) dut (
        .CLK   (clk),
        .RESET (rst),
        .I     (i_ring),
        .CE    (ce),
        .O     (o_led)
    );

    led_trail_pwm #(.N(8), .BW(4), .DECAY(3)) dut3 (
        .CLK   (clk),
        .RESET (rst),
        .I     (i_ring3),
        .CE    (ce3),
        .O     (o_led3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_duty(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) >> 4;
`else
        return l;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Apply inputs for n cycles starting at a falling edge, then clear them.
    task automatic drive(input logic [7:0] imask, input bit ce_v, input int n, input bit use3);
        if (use3) begin
            i_ring3 = imask;
            ce3     = ce_v;
        end else begin
            i_ring = imask;
            ce     = ce_v;
        end
        repeat (n) cyc();
        i_ring  = '0;
        ce      = 1'b0;
        i_ring3 = '0;
        ce3     = 1'b0;
    endtask

    task automatic measure(input bit use3, input int b, output int ones, output logic [7:0] orv);
        logic [7:0] s;
        ones = 0;
        orv  = '0;
        for (int n = 0; n < 16; n++) begin
            cyc();
            s    = use3 ? o_led3 : o_led;
            ones += int'(s[b]);
            orv  |= s;
        end
    endtask

    initial begin
        int         ones;
        logic [7:0] orv;
        bit         found;

        rst     = 1'b0;
        i_ring  = '0;
        ce      = 1'b0;
        i_ring3 = '0;
        ce3     = 1'b0;

        // Reset at power-up must clear outputs before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_async_O", int'(o_led), 0);
        chk("reset_async_O3", int'(o_led3), 0);
        cyc();
        cyc();
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            cyc();
            chk("pwm_cnt_after_release", int'(dut.r_pwm_cnt), n);
            chk("O_idle_after_release", int'(o_led), 0);
        end

        // Refill on bit 0; counter is 3 here, 4 after the sampling edge.
        i_ring = 8'h01;
        cyc();
        i_ring = '0;
        chk("refill_edge1_O", int'(o_led), 0);
        cyc();
        chk("refill_edge2_O", int'(o_led), 1);
        measure(1'b0, 0, ones, orv);
        chk("refill_duty", ones, exp_duty(15));
        chk("refill_other_bits", int'(orv[7:1]), 0);

        // Fade: one CE per step; duty drops by one until it pins at zero.
        for (int k = 1; k <= 17; k++) begin
            drive(8'h00, 1'b1, 1, 1'b0);
            measure(1'b0, 0, ones, orv);
            chk($sformatf("fade_step%0d_duty", k), ones, exp_duty((15 - k) < 0 ? 0 : 15 - k));
        end
        chk("fade_all_dark", int'(orv), 0);

        // Priority: bring bit 3 to 5 with CE held 10 cycles, then refill+CE.
        drive(8'h08, 1'b0, 1, 1'b0);
        drive(8'h00, 1'b1, 10, 1'b0);
        measure(1'b0, 3, ones, orv);
        chk("prio_lvl5_duty", ones, exp_duty(5));
        drive(8'h08, 1'b1, 1, 1'b0);
        measure(1'b0, 3, ones, orv);
        chk("prio_refill_wins_duty", ones, exp_duty(15));

        // DECAY=3 build: 15 -> 3 after four ticks, then 0, then stays 0.
        drive(8'h01, 1'b0, 1, 1'b1);
        drive(8'h00, 1'b1, 4, 1'b1);
        measure(1'b1, 0, ones, orv);
        chk("decay3_lvl3_duty", ones, exp_duty(3));
        drive(8'h00, 1'b1, 1, 1'b1);
        measure(1'b1, 0, ones, orv);
        chk("decay3_sat_zero_duty", ones, 0);
        drive(8'h00, 1'b1, 1, 1'b1);
        measure(1'b1, 0, ones, orv);
        chk("decay3_no_wrap_duty", ones, 0);

        // Gamma / linear mapping at levels 8 and 15 on bit 0.
        drive(8'h01, 1'b0, 1, 1'b0);
        drive(8'h00, 1'b1, 7, 1'b0);
        measure(1'b0, 0, ones, orv);
`ifdef LED_TRAIL_GAMMA_EN
        chk("map_lvl8_duty", ones, 4);
`else
        chk("map_lvl8_duty", ones, 8);
`endif
        drive(8'h01, 1'b0, 1, 1'b0);
        measure(1'b0, 0, ones, orv);
`ifdef LED_TRAIL_GAMMA_EN
        chk("map_lvl15_duty", ones, 14);
`else
        chk("map_lvl15_duty", ones, 15);
`endif

        // Mid-period reset with every LED lit and the counter at 7.
        i_ring = 8'hFF;
        found  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (n >= 2 && dut.r_pwm_cnt == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("midreset_cnt7_found", int'(found), 1);
        chk("midreset_O_full", int'(o_led), 8'hFF);
        #2 rst = 1'b1;
        #1;
        chk("midreset_async_O", int'(o_led), 0);
        i_ring = '0;
        cyc();
        rst = 1'b0;
        cyc();
        chk("midreset_cnt_restart", int'(dut.r_pwm_cnt), 1);
        measure(1'b0, 0, ones, orv);
        chk("midreset_levels_zero", int'(orv), 0);
        drive(8'h01, 1'b0, 1, 1'b0);
        measure(1'b0, 0, ones, orv);
        chk("midreset_refill_duty", ones, exp_duty(15));
        drive(8'h00, 1'b1, 1, 1'b0);
        measure(1'b0, 0, ones, orv);
        chk("midreset_fade_duty", ones, exp_duty(14));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
